pc_fetch_unit: RTL and testbench

//  - Program-counter stage of the MIPS datapath: holds PC, computes PC+4, branch and jump targets,
//    and registers the selected next PC. Drives the instruction-memory address.
//  - Sits directly downstream of the next-PC 2:1 selection (sequential vs branch) and consumes it.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_fetch_if.sv | 26 ++
 rtl/mux2_1.sv | 9 +
 rtl/pc_next_logic.sv | 47 ++++
 rtl/pc_fetch_unit.sv | 72 +++++++
 tb/tb_pc_fetch_unit.sv | 149 ++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch datapath.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int PC_STEP          = 4;
    localparam int INSTR_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_fetch_if.sv
// Redirect-request and fetch-address bundle between the control path and the PC stage.
interface pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic [25:0]      jump_index;
    logic             jr;
    logic [WIDTH-1:0] jr_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             instr_valid;
    logic             fault;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index, jr, jr_addr,
        input  pc, pc_plus4, instr_valid, fault
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index, jr, jr_addr,
        output pc, pc_plus4, instr_valid, fault
    );
endinterface

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer: y = sel ? b : a.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/pc_next_logic.sv
// Combinational next-PC formation: PC+4, branch/jump targets and prioritized select.
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] seq_or_branch;

    // All arithmetic wraps modulo 2^WIDTH; no overflow is reported.
    assign pc_plus4      = pc + WIDTH'(PC_STEP);
    assign branch_target = pc_plus4 + (branch_offset << INSTR_ALIGN_BITS);

    // J-type target keeps the 256 MB region of the delay-slot address, so WIDTH is 32.
    assign jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00};

    for (genvar i = 0; i < WIDTH; i++) begin : g_seq_mux
        mux2_1 u_mux (
            .a   (pc_plus4[i]),
            .b   (branch_target[i]),
            .sel (branch_taken),
            .y   (seq_or_branch[i])
        );
    end

    assign misaligned = jr && (jr_addr[INSTR_ALIGN_BITS-1:0] != '0);

    always_comb begin
        next_pc = seq_or_branch;
        if (jr)
            next_pc = jr_addr;
        else if (jump)
            next_pc = jump_target;
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// PC stage: holds the fetch address, sequences BOOT/RUN/HALT and latches JR alignment faults.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.slave  bus
);
    fetch_state_t     state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;
    logic             misaligned;
    logic             valid_q;
    logic             fault_q;

    pc_next_logic #(.WIDTH(WIDTH)) u_next (
        .pc            (pc_q),
        .branch_taken  (bus.branch_taken),
        .branch_offset (bus.branch_offset),
        .jump          (bus.jump),
        .jump_index    (bus.jump_index),
        .jr            (bus.jr),
        .jr_addr       (bus.jr_addr),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // Stall is tested before any request input is used, so unknown requests under stall cannot disturb state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (misaligned) begin
                            state   <= HALT;
                            valid_q <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= HALT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequencing, branch, jump priority, stall, wrap and fault.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_fetch_if #(.WIDTH(32)) bus ();

    pc_fetch_unit #(.WIDTH(32), .RESET_ADDR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.jump          = 1'b0;
        bus.jump_index    = '0;
        bus.jr            = 1'b0;
        bus.jr_addr       = '0;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        clear_req();
        bus.jr      = 1'b1;
        bus.jr_addr = addr;
        step();
        clear_req();
    endtask

    initial begin
        clear_req();
        rst = 1'b1;
        step();
        step();
        check("rst_pc",    bus.pc, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_fault", 32'(bus.fault), 32'h0);

        // Leave reset: BOOT is the cycle just observed, RUN follows.
        rst = 1'b0;
        step();
        check("run0_pc",    bus.pc, 32'h0);
        check("run0_valid", 32'(bus.instr_valid), 32'h1);
        check("run0_p4",    bus.pc_plus4, 32'h4);
        step(); check("seq_4", bus.pc, 32'h4);
        step(); check("seq_8", bus.pc, 32'h8);
        step(); check("seq_c", bus.pc, 32'hC);
        step(); check("seq_10", bus.pc, 32'h10);

        // Branch backwards and forwards from 0x10.
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'hFFFF_FFFE;
        step(); check("br_neg", bus.pc, 32'hC);
        jr_to(32'h10);
        check("jr_10", bus.pc, 32'h10);
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'h0000_0003;
        step(); check("br_pos", bus.pc, 32'h20);

        // Jump beats branch; jr beats both.
        jr_to(32'h4000_0000);
        check("jr_4000", bus.pc, 32'h4000_0000);
        bus.jump          = 1'b1;
        bus.jump_index    = 26'h000_0040;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 32'h0000_0010;
        step(); check("jmp_pri", bus.pc, 32'h4000_0100);
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h0000_0200;
        step(); check("jr_pri", bus.pc, 32'h0000_0200);

        // Stall drops redirects and holds pc.
        jr_to(32'h8);
        bus.stall      = 1'b1;
        bus.jump       = 1'b1;
        bus.jump_index = 26'h000_1000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus.pc, 32'h8);
        end
        check("stall_valid", 32'(bus.instr_valid), 32'h1);
        clear_req();
        step(); check("unstall_pc", bus.pc, 32'hC);

        // Sequential wrap past the top of the address space.
        jr_to(32'hFFFF_FFFC);
        check("wrap_top",   bus.pc, 32'hFFFF_FFFC);
        check("wrap_top4",  bus.pc_plus4, 32'h0);
        step();
        check("wrap_pc",    bus.pc, 32'h0);
        check("wrap_p4",    bus.pc_plus4, 32'h4);
        check("wrap_fault", 32'(bus.fault), 32'h0);

        // Misaligned jr: pc frozen, fault sticky, fetch stops until reset.
        step(); check("pre_fault_pc", bus.pc, 32'h4);
        bus.jr      = 1'b1;
        bus.jr_addr = 32'h0000_0102;
        step();
        check("flt_pc",    bus.pc, 32'h4);
        check("flt_fault", 32'(bus.fault), 32'h1);
        check("flt_valid", 32'(bus.instr_valid), 32'h0);
        clear_req();
        bus.stall = 1'b1;
        step();
        bus.stall = 1'b0;
        bus.jump  = 1'b1;
        step();
        check("halt_pc",    bus.pc, 32'h4);
        check("halt_fault", 32'(bus.fault), 32'h1);
        check("halt_valid", 32'(bus.instr_valid), 32'h0);

        // Reset recovers; stall is ignored while in BOOT.
        clear_req();
        rst = 1'b1;
        step();
        check("rst2_fault", 32'(bus.fault), 32'h0);
        check("rst2_valid", 32'(bus.instr_valid), 32'h0);
        check("rst2_pc",    bus.pc, 32'h0);
        rst       = 1'b0;
        bus.stall = 1'b1;
        step();
        check("boot_stall_valid", 32'(bus.instr_valid), 32'h1);
        step(); check("run_stall_pc", bus.pc, 32'h0);
        bus.stall = 1'b0;
        step(); check("resume_pc", bus.pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
